// File: rtl/store_commit_queue.sv
// Store commit queue: holds issued stores until the ROB commits them, drains
// committed stores in order to data memory and serves store-to-load forwarding.
module store_commit_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sq_valid,
  output logic                     o_sq_ready,
  input  logic [DATA_W-1:0]        i_sq_instr_no,
  input  logic [DATA_W-1:0]        i_sq_addr,
  input  logic [DATA_W-1:0]        i_sq_data,
  input  logic                     i_rob_commit_valid,
  input  logic [DATA_W-1:0]        i_rob_commit_no,
  input  logic                     i_rob_flush,
  output logic                     o_commit_ack,
  output logic                     o_commit_miss,
  output logic                     o_mem_wr_req,
  output logic [DATA_W-1:0]        o_mem_wr_addr,
  output logic [DATA_W-1:0]        o_mem_wr_data,
  input  logic                     i_mem_wr_ack,
  input  logic [DATA_W-1:0]        i_fwd_addr,
  output logic                     o_fwd_hit,
  output logic [DATA_W-1:0]        o_fwd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [AW-1:0]     r_head, r_tail, r_cptr;
  logic [AW:0]       r_count;
  logic              r_valid     [DEPTH];
  logic              r_committed [DEPTH];
  logic [DATA_W-1:0] r_instr     [DEPTH];
  logic [DATA_W-1:0] r_addr      [DEPTH];
  logic [DATA_W-1:0] r_data      [DEPTH];
  logic [0:0]        r_state;
  logic              r_mem_req, r_commit_ack, r_commit_miss;
  logic [DATA_W-1:0] r_mem_addr, r_mem_data;

  logic              w_ready, w_enq, w_commit_hit, w_pop, w_launch;
  logic [AW-1:0]     w_cptr_next;
  logic [AW:0]       w_kept_cnt, w_kept_next;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_unused_fwd_lsb;

  assign w_ready      = (r_count < L_DEPTH);
  assign w_enq        = i_sq_valid && w_ready && !i_rob_flush;
  assign w_commit_hit = i_rob_commit_valid && r_valid[r_cptr] && !r_committed[r_cptr]
                        && (r_instr[r_cptr] == i_rob_commit_no);
  assign w_pop        = (r_state == S_WRITE) && i_mem_wr_ack;
  assign w_launch     = (r_state == S_IDLE) && r_valid[r_head] && r_committed[r_head];
  assign w_cptr_next  = w_commit_hit ? r_cptr + 1'b1 : r_cptr;
  assign w_unused_fwd_lsb = ^i_fwd_addr[1:0];

  // Committed entries survive a flush; count them to rebuild the occupancy.
  always_comb begin
    w_kept_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_committed[i]) w_kept_cnt = w_kept_cnt + 1'b1;
    end
  end
  assign w_kept_next = w_kept_cnt + (AW+1)'(w_commit_hit) - (AW+1)'(w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      r_cptr <= w_cptr_next;
      if (i_rob_flush) begin
        r_tail  <= w_cptr_next;
        r_count <= w_kept_next;
      end else begin
        if (w_enq) r_tail <= r_tail + 1'b1;
        r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_pop);
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_valid[gi]     <= 1'b0;
        r_committed[gi] <= 1'b0;
      end else if (w_pop && (r_head == AW'(gi))) begin
        r_valid[gi]     <= 1'b0;
        r_committed[gi] <= 1'b0;
      end else if (w_enq && (r_tail == AW'(gi))) begin
        r_valid[gi]     <= 1'b1;
        r_committed[gi] <= 1'b0;
      end else if (w_commit_hit && (r_cptr == AW'(gi))) begin
        r_committed[gi] <= 1'b1;
      end else if (i_rob_flush && !r_committed[gi]) begin
        r_valid[gi]     <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_instr[r_tail] <= i_sq_instr_no;
      r_addr[r_tail]  <= i_sq_addr;
      r_data[r_tail]  <= i_sq_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_commit_ack  <= 1'b0;
      r_commit_miss <= 1'b0;
    end else begin
      r_commit_ack  <= w_commit_hit;
      r_commit_miss <= i_rob_commit_valid && !w_commit_hit;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr[r_head];
            r_mem_data <= r_data[r_head];
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (i_mem_wr_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    logic [AW-1:0] idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + AW'(i);
      if (r_valid[idx] && (r_addr[idx][DATA_W-1:2] == i_fwd_addr[DATA_W-1:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[idx];
      end
    end
  end

  assign o_sq_ready    = w_ready;
  assign o_commit_ack  = r_commit_ack;
  assign o_commit_miss = r_commit_miss;
  assign o_mem_wr_req  = r_mem_req;
  assign o_mem_wr_addr = r_mem_addr;
  assign o_mem_wr_data = r_mem_data;
  assign o_fwd_hit     = w_fwd_hit;
  assign o_fwd_data    = w_fwd_data;
  assign o_count       = r_count;

endmodule
